cfu_master_port: RTL

- CPU-side initiator for the CFU request/response protocol; sits between the execute-stage issue logic and any `cfu_interface.slave` block.
- Registers issued CFU operations onto `cfu_interface.master` and limits outstanding requests.
- Checks that responses return in issue order, and presents results on a single-entry writeback register.
- Flags a stalled CFU with a watchdog.

---
 rtl/cfu_master_pkg.sv | 22 ++
 rtl/cfu_interface.sv | 31 +++
 rtl/cfu_id_fifo.sv | 51 +++++
 rtl/cfu_master_port.sv | 132 +++++++++++++
 4 files changed

// File: rtl/cfu_master_pkg.sv
// Shared types and widths for the CFU master port and its request/response interface.
// No logic here; latency and backpressure are defined by the modules that use these types.
// Struct widths follow the default port widths; override the port parameters together with these.
package cfu_master_pkg;
    localparam int FUNCT_W    = 10;
    localparam int STATUS_W   = 2;
    localparam int CFU_ID_W   = 2;
    localparam int CFU_DATA_W = 32;

    typedef struct packed {
        logic [CFU_ID_W-1:0]   id;
        logic [FUNCT_W-1:0]    function_id;
        logic [CFU_DATA_W-1:0] data0;
        logic [CFU_DATA_W-1:0] data1;
    } cfu_req_t;

    typedef struct packed {
        logic [CFU_ID_W-1:0]   id;
        logic [CFU_DATA_W-1:0] data;
        logic                  err;
    } cfu_wb_t;
endpackage

// File: rtl/cfu_interface.sv
// CFU request/response bundle shared by the CPU-side master and any CFU slave.
// Pure wiring: no latency of its own.
// Valid/ready on both the request and the response channel.
interface cfu_interface #(
    parameter int ID_W   = 2,
    parameter int DATA_W = 32
);
    import cfu_master_pkg::*;

    logic                req_valid;
    logic                req_ready;
    logic [ID_W-1:0]     req_id;
    logic [FUNCT_W-1:0]  req_function_id;
    logic [DATA_W-1:0]   req_data0;
    logic [DATA_W-1:0]   req_data1;
    logic                resp_valid;
    logic                resp_ready;
    logic [ID_W-1:0]     resp_id;
    logic [STATUS_W-1:0] resp_status;
    logic [DATA_W-1:0]   resp_data;

    modport master (
        output req_valid, req_id, req_function_id, req_data0, req_data1, resp_ready,
        input  req_ready, resp_valid, resp_id, resp_status, resp_data
    );

    modport slave (
        input  req_valid, req_id, req_function_id, req_data0, req_data1, resp_ready,
        output req_ready, resp_valid, resp_id, resp_status, resp_data
    );
endinterface

// File: rtl/cfu_id_fifo.sv
// Circular FIFO of issued ids; head shows the oldest id combinationally.
// Push lands one cycle later; pop takes effect at the clock edge.
// No backpressure of its own: push while full is accepted only alongside a pop.
module cfu_id_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Index wraps at DEPTH (not a power of two in general); the top bit toggles on wrap.
    function automatic logic [AW:0] ptr_inc(input logic [AW:0] p);
        if (p[AW-1:0] == LAST) return {~p[AW], {AW{1'b0}}};
        return p + 1'b1;
    endfunction

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    assign head    = mem[rd_ptr[AW-1:0]];
    assign do_push = push & (!full | pop);
    assign do_pop  = pop & !empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= ptr_inc(wr_ptr);
            if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_dat;
    end
endmodule

// File: rtl/cfu_master_port.sv
// CPU-side CFU initiator: registers issues onto the CFU bus, checks response order, holds one writeback.
// Latency: issue->req_valid 1 cycle, resp->wb_valid 1 cycle; one op per cycle in each direction.
// Backpressure: issue_ready drops on req stall or outstanding limit; a held writeback stalls resp_ready only.
module cfu_master_port
    import cfu_master_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 2,
    parameter int ID_W            = CFU_ID_W,
    parameter int DATA_W          = CFU_DATA_W,
    parameter int TIMEOUT_CYCLES  = 1024
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               issue_valid,
    output logic               issue_ready,
    input  logic [ID_W-1:0]    issue_id,
    input  logic [FUNCT_W-1:0] issue_funct,
    input  logic [DATA_W-1:0]  issue_rs1,
    input  logic [DATA_W-1:0]  issue_rs2,
    cfu_interface.master       cfu,
    output logic               wb_valid,
    input  logic               wb_ack,
    output logic [ID_W-1:0]    wb_id,
    output logic [DATA_W-1:0]  wb_data,
    output logic               wb_err,
    output logic               cfu_hung,
    output logic               id_mismatch
);
    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam int SUM_W = CNT_W + 1;
    localparam int WD_W  = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] OUT_MAX = CNT_W'(MAX_OUTSTANDING);
    localparam logic [WD_W-1:0]  WD_MAX  = WD_W'(TIMEOUT_CYCLES - 1);

    cfu_req_t         req_q;
    logic             req_vld_q;
    cfu_wb_t          wb_q;
    logic             wb_vld_q;
    logic [CNT_W-1:0] outstanding;
    logic [WD_W-1:0]  wdog;
    logic             issue_hs, req_hs, resp_hs, wb_hs;
    logic             fifo_full, fifo_empty, head_miss;
    logic [ID_W-1:0]  fifo_head;

    assign issue_hs = issue_valid & issue_ready;
    assign req_hs   = req_vld_q & cfu.req_ready;
    assign resp_hs  = cfu.resp_valid & cfu.resp_ready;
    assign wb_hs    = wb_vld_q & wb_ack;

    assign issue_ready = (!req_vld_q | cfu.req_ready) &
                         ((SUM_W'(outstanding) + SUM_W'(req_vld_q)) < SUM_W'(MAX_OUTSTANDING));

    assign cfu.req_valid       = req_vld_q;
    assign cfu.req_id          = req_q.id;
    assign cfu.req_function_id = req_q.function_id;
    assign cfu.req_data0       = req_q.data0;
    assign cfu.req_data1       = req_q.data1;
    assign cfu.resp_ready      = !wb_vld_q | wb_ack;

    assign wb_valid = wb_vld_q;
    assign wb_id    = wb_q.id;
    assign wb_data  = wb_q.data;
    assign wb_err   = wb_q.err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_vld_q <= 1'b0;
            req_q     <= '0;
        end else if (issue_hs) begin
            req_vld_q <= 1'b1;
            req_q     <= '{id: issue_id, function_id: issue_funct, data0: issue_rs1, data1: issue_rs2};
        end else if (req_hs) begin
            req_vld_q <= 1'b0;
        end
    end

    // Counts ops from request handshake until their result leaves the writeback register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            outstanding <= '0;
        end else if (req_hs && !wb_hs && outstanding != OUT_MAX) begin
            outstanding <= outstanding + 1'b1;
        end else if (wb_hs && !req_hs && outstanding != '0) begin
            outstanding <= outstanding - 1'b1;
        end
    end

    cfu_id_fifo #(.DEPTH(MAX_OUTSTANDING), .WIDTH(ID_W)) u_id_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (req_hs),
        .push_dat (req_q.id),
        .pop      (resp_hs),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .head     (fifo_head)
    );

    // A response with nothing in flight is treated like an out-of-order id.
    assign head_miss = fifo_empty | (cfu.resp_id != fifo_head);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_vld_q    <= 1'b0;
            wb_q        <= '0;
            id_mismatch <= 1'b0;
        end else if (resp_hs) begin
            wb_vld_q <= 1'b1;
            wb_q     <= '{id: cfu.resp_id, data: cfu.resp_data,
                          err: (cfu.resp_status != '0) | head_miss};
            if (head_miss) id_mismatch <= 1'b1;
        end else if (wb_hs) begin
            wb_vld_q <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wdog     <= '0;
            cfu_hung <= 1'b0;
        end else if (resp_hs || outstanding == '0) begin
            wdog <= '0;
        end else if (wdog != WD_MAX) begin
            wdog <= wdog + 1'b1;
            if (wdog == WD_MAX - 1'b1) cfu_hung <= 1'b1;
        end
    end

    assert property (@(posedge clk) disable iff (rst) !(req_hs && !wb_hs && outstanding == OUT_MAX));
    assert property (@(posedge clk) disable iff (rst) !(wb_hs && !req_hs && outstanding == '0));
    assert property (@(posedge clk) disable iff (rst) !(req_hs && fifo_full && !resp_hs));
endmodule
